instr_loader: RTL

//   Inverse of the control decoder: takes symbolic instructions (mnemonic code plus rs/rt/rd/shamt/imm16/addr26),

---
 rtl/instr_loader_pkg.sv | 71 +++++++
 rtl/instr_loader_pack.sv | 43 ++++
 rtl/instr_loader.sv | 111 +++++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
// Shared constants for the instruction loader: mnemonic codes, MIPS opcodes and
// funct codes, loader FSM states, and word-packing helpers.
package instr_loader_pkg;

  // Symbolic mnemonic codes presented on in_mn; unlisted codes are illegal.
  typedef enum logic [4:0] {
    MN_ADD  = 5'd0,
    MN_SUB  = 5'd1,
    MN_AND  = 5'd2,
    MN_OR   = 5'd3,
    MN_NOR  = 5'd4,
    MN_SLT  = 5'd5,
    MN_SLL  = 5'd6,
    MN_SRL  = 5'd7,
    MN_ADDI = 5'd8,
    MN_ANDI = 5'd9,
    MN_ORI  = 5'd10,
    MN_BEQ  = 5'd11,
    MN_BNE  = 5'd12,
    MN_LW   = 5'd13,
    MN_SW   = 5'd14,
    MN_J    = 5'd15,
    MN_JAL  = 5'd16
  } mn_e;

  // Primary opcodes.
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type funct codes.
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Loader FSM states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } ld_state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {OPC_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] addr);
    return {op, addr};
  endfunction

endpackage

// File: rtl/instr_loader_pack.sv
// Combinational packer: mnemonic plus operand fields -> 32-bit MIPS word and a
// legality flag. Fields the operation does not use are forced to zero.
module instr_pack
  import instr_loader_pkg::*;
(
  input  logic [4:0]  mn_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] addr26_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  // Select the encoding format and fill in the opcode/funct for each mnemonic.
  always_comb begin
    word_o  = '0;
    legal_o = 1'b1;
    case (mn_e'(mn_i))
      MN_ADD:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_ADD);
      MN_SUB:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SUB);
      MN_AND:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_AND);
      MN_OR:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_OR);
      MN_NOR:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_NOR);
      MN_SLT:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SLT);
      MN_SLL:  word_o = r_word(5'd0, rt_i, rd_i, shamt_i, FN_SLL);
      MN_SRL:  word_o = r_word(5'd0, rt_i, rd_i, shamt_i, FN_SRL);
      MN_ADDI: word_o = i_word(OPC_ADDI, rs_i, rt_i, imm16_i);
      MN_ANDI: word_o = i_word(OPC_ANDI, rs_i, rt_i, imm16_i);
      MN_ORI:  word_o = i_word(OPC_ORI, rs_i, rt_i, imm16_i);
      MN_BEQ:  word_o = i_word(OPC_BEQ, rs_i, rt_i, imm16_i);
      MN_BNE:  word_o = i_word(OPC_BNE, rs_i, rt_i, imm16_i);
      MN_LW:   word_o = i_word(OPC_LW, rs_i, rt_i, imm16_i);
      MN_SW:   word_o = i_word(OPC_SW, rs_i, rt_i, imm16_i);
      MN_J:    word_o = j_word(OPC_J, addr26_i);
      MN_JAL:  word_o = j_word(OPC_JAL, addr26_i);
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: accepts symbolic instructions, packs them into MIPS words
// and streams them into instruction memory, holding the core in reset until the
// program has been completely loaded.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [4:0]        in_mn,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm16,
  input  logic [25:0]       in_addr26,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic [31:0]       pack_word;
  logic              pack_legal;
  logic              xfer;

  instr_pack u_pack (
    .mn_i     (in_mn),
    .rs_i     (in_rs),
    .rt_i     (in_rt),
    .rd_i     (in_rd),
    .shamt_i  (in_shamt),
    .imm16_i  (in_imm16),
    .addr26_i (in_addr26),
    .word_o   (pack_word),
    .legal_o  (pack_legal)
  );

  assign in_ready  = (state_q == ST_LOAD);
  assign xfer      = in_valid && in_ready;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERR);
  assign cpu_hold  = (state_q != ST_DONE);

  // Next-state, counter and write-port computation.
  // A beat accepted on the same edge as start still writes at its old address;
  // start then takes over state and count.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (xfer) begin
      if (!pack_legal || (count_q == DEPTH_C)) begin
        state_d = ST_ERR;
      end else begin
        mem_we_d    = 1'b1;
        mem_addr_d  = count_q[ADDR_W-1:0];
        mem_wdata_d = pack_word;
        count_d     = count_q + 1'b1;
        if (in_last) begin
          state_d = ST_DONE;
        end
      end
    end
    if (start) begin
      state_d = ST_LOAD;
      count_d = '0;
    end
  end

  // State, counter and registered write-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule
